// File: rtl/clock_disp_pkg.sv
// Shared constants, snapshot type and segment encoder for the clock display scanner.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package clock_disp_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef struct packed {
    logic [5:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
    logic       am_pm;
    logic       am_mode;
  } snap_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd60.sv
// Combinational 6-bit binary to two BCD digits for values 0..59.
// Values above 59 raise invalid; the digit outputs are then meaningless.
module bin2bcd60 (
  input  logic [5:0] val,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       invalid
);

  logic [5:0] base;

  always_comb begin
    tens = 4'd0;
    base = 6'd0;
    if (val >= 6'd60) begin
      tens = 4'd6;
      base = 6'd60;
    end else if (val >= 6'd50) begin
      tens = 4'd5;
      base = 6'd50;
    end else if (val >= 6'd40) begin
      tens = 4'd4;
      base = 6'd40;
    end else if (val >= 6'd30) begin
      tens = 4'd3;
      base = 6'd30;
    end else if (val >= 6'd20) begin
      tens = 4'd2;
      base = 6'd20;
    end else if (val >= 6'd10) begin
      tens = 4'd1;
      base = 6'd10;
    end
    ones    = 4'(val - base);
    invalid = (val > 6'd59);
  end

endmodule

// File: rtl/clock_display_scanner.sv
// Multiplexed 6-digit common-anode display driver for HH MM SS with per-frame snapshot,
// 12-hour leading-zero blanking, blinking colon on even seconds and buzzer flash.
module clock_display_scanner
  import clock_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned BLINK_DIV   = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] hr,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       AM_PM,
  input  logic       AM_mode,
  input  logic       alarm_buzzer,
  input  logic       timer_buzzer,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       pm_led
);

  localparam int unsigned RefW = $clog2(REFRESH_DIV);
  localparam int unsigned BlkW = $clog2(BLINK_DIV);
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);

  logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
  logic [BlkW-1:0] blink_cnt_q, blink_cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            blink_phase_q, blink_phase_d;
  snap_t           snap_q, snap_d;
  logic [5:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic       ref_wrap, buzz;
  logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic       hr_bad, min_bad, sec_bad;
  logic [3:0] digit;
  logic       field_bad, digit_blank;

  bin2bcd60 u_hr  (.val(snap_q.hr),  .tens(hr_tens),  .ones(hr_ones),  .invalid(hr_bad));
  bin2bcd60 u_min (.val(snap_q.min), .tens(min_tens), .ones(min_ones), .invalid(min_bad));
  bin2bcd60 u_sec (.val(snap_q.sec), .tens(sec_tens), .ones(sec_ones), .invalid(sec_bad));

  assign ref_wrap = (ref_cnt_q == RefW'(REFRESH_DIV - 1));
  assign buzz     = alarm_buzzer | timer_buzzer;

  always_comb begin
    ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + RefW'(1);
    idx_d     = idx_q;
    snap_d    = snap_q;
    if (ref_wrap) begin
      if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
        idx_d  = '0;
        // Latch the whole frame at once so a mid-frame time change cannot tear the display.
        snap_d = '{hr: hr, min: min, sec: sec, am_pm: AM_PM, am_mode: AM_mode};
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  always_comb begin
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if (buzz) begin
      blink_phase_d = blink_phase_q;
      if (blink_cnt_q == BlkW'(BLINK_DIV - 1)) begin
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlkW'(1);
      end
    end
  end

  always_comb begin
    digit       = 4'd0;
    field_bad   = 1'b0;
    digit_blank = 1'b0;
    case (idx_q)
      IdxW'(0): begin digit = sec_ones; field_bad = sec_bad; end
      IdxW'(1): begin digit = sec_tens; field_bad = sec_bad; end
      IdxW'(2): begin digit = min_ones; field_bad = min_bad; end
      IdxW'(3): begin digit = min_tens; field_bad = min_bad; end
      IdxW'(4): begin digit = hr_ones;  field_bad = hr_bad;  end
      default: begin
        digit       = hr_tens;
        field_bad   = hr_bad;
        digit_blank = snap_q.am_mode && (hr_tens == 4'd0);
      end
    endcase

    if (field_bad) begin
      seg_d = SEG_DASH;
    end else if (digit_blank) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_encode(digit);
    end

    an_d = (buzz && blink_phase_q) ? 6'b111111 : ~(6'b000001 << idx_q);
    dp_d = ~(((idx_q == IdxW'(2)) || (idx_q == IdxW'(4))) && !snap_q.sec[0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      idx_q         <= '0;
      blink_phase_q <= 1'b0;
      snap_q        <= '0;
      an_q          <= 6'b111111;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      ref_cnt_q     <= ref_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      idx_q         <= idx_d;
      blink_phase_q <= blink_phase_d;
      snap_q        <= snap_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an     = an_q;
  assign seg    = seg_q;
  assign dp     = dp_q;
  assign pm_led = snap_q.am_mode & snap_q.am_pm;

endmodule

// File: tb/tb_clock_display_scanner.sv
// Scoreboard bench: stimulus queues expected {an,seg,dp,pm_led} per digit change;
// the monitor pops and compares every time the anode pattern changes.
module tb_clock_display_scanner;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pm;
  } exp_t;

  logic       clk, reset;
  logic [5:0] hr, min, sec;
  logic       AM_PM, AM_mode, alarm_buzzer, timer_buzzer;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp, pm_led;

  exp_t       exp_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         n_evt  = 0;
  int         cyc;
  logic       done = 1'b0;
  logic [5:0] prev_an = 6'b111111;

  clock_display_scanner #(
    .REFRESH_DIV(4),
    .BLINK_DIV  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hr          (hr),
    .min         (min),
    .sec         (sec),
    .AM_PM       (AM_PM),
    .AM_mode     (AM_mode),
    .alarm_buzzer(alarm_buzzer),
    .timer_buzzer(timer_buzzer),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .pm_led      (pm_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required end before 100000", $time);
    $fatal(1);
  end

  task automatic push(input logic [5:0] a, input logic [6:0] s, input logic d, input logic p);
    exp_t e;
    e.an  = a;
    e.seg = s;
    e.dp  = d;
    e.pm  = p;
    exp_q.push_back(e);
  endtask

  task automatic push_dig(input int idx, input logic [6:0] s, input logic d, input logic p);
    logic [5:0] one;
    one = 6'b000001;
    push(~(one << idx), s, d, p);
  endtask

  // Digits in scan order: sec ones, sec tens, min ones, min tens, hr ones, hr tens.
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5,
                            input logic colon, input logic p);
    push_dig(0, s0, 1'b1, p);
    push_dig(1, s1, 1'b1, p);
    push_dig(2, s2, colon, p);
    push_dig(3, s3, 1'b1, p);
    push_dig(4, s4, colon, p);
    push_dig(5, s5, 1'b1, p);
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_chk++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL leftover: %0d expected digit events never seen, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end else if (an !== prev_an) begin
      n_evt++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL event %0d: unexpected an=%b seg=%b dp=%b at cyc %0d, required none",
                 n_evt, an, seg, dp, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({an, seg, dp, pm_led} !== {e.an, e.seg, e.dp, e.pm}) begin
          n_fail++;
          $display("FAIL event %0d cyc %0d: got an=%b seg=%b dp=%b pm=%b, required an=%b seg=%b dp=%b pm=%b",
                   n_evt, cyc, an, seg, dp, pm_led, e.an, e.seg, e.dp, e.pm);
        end
      end
    end
    prev_an = an;
  end

  initial begin
    reset = 1'b1;
    hr = 6'd9; min = 6'd5; sec = 6'd42;
    AM_PM = 1'b0; AM_mode = 1'b0;
    alarm_buzzer = 1'b0; timer_buzzer = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    // Partial zero-snapshot frame, then reset mid-scan blanks everything.
    push_dig(0, S0, 1'b1, 1'b0);
    push_dig(1, S0, 1'b1, 1'b0);
    push_dig(2, S0, 1'b0, 1'b0);
    push(6'b111111, SB, 1'b1, 1'b0);
    wait_cyc(10);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Frame 0 shows the all-zero snapshot with hour tens visible; frame 1 shows 09:05:42.
    push_frame(S0, S0, S0, S0, S0, S0, 1'b0, 1'b0);
    push_frame(S2, S4, S5, S0, S9, S0, 1'b0, 1'b0);

    // 12-hour PM with odd seconds: 3:59:43, hour tens blank, colon off.
    wait_cyc(30);
    hr = 6'd3; min = 6'd59; sec = 6'd43; AM_mode = 1'b1; AM_PM = 1'b1;
    push_frame(S3, S4, S9, S5, S3, SB, 1'b1, 1'b1);

    // Minute changes while idx = 3: invisible until the next frame.
    wait_cyc(61);
    min = 6'd0;
    push_frame(S3, S4, S0, S0, S3, SB, 1'b1, 1'b1);

    // Invalid seconds show dashes; 24-hour mode shows the leading hour zero.
    wait_cyc(80);
    sec = 6'd63; AM_mode = 1'b0;
    push_frame(SD, SD, S0, S0, S3, S0, 1'b1, 1'b0);

    // Alarm flash from edge 121: blank 129..136, 145..152, 161..; dropped before edge 164.
    wait_cyc(120);
    alarm_buzzer = 1'b1;
    push_dig(0, SD, 1'b1, 1'b0);
    push_dig(1, SD, 1'b1, 1'b0);
    push(6'b111111, S0, 1'b1, 1'b0);
    push_dig(4, S3, 1'b1, 1'b0);
    push_dig(5, S0, 1'b1, 1'b0);
    push(6'b111111, SD, 1'b1, 1'b0);
    push_dig(2, S0, 1'b1, 1'b0);
    push_dig(3, S0, 1'b1, 1'b0);
    push(6'b111111, S3, 1'b1, 1'b0);

    wait_cyc(163);
    alarm_buzzer = 1'b0;
    push_dig(4, S3, 1'b1, 1'b0);
    push_dig(5, S0, 1'b1, 1'b0);
    push_dig(0, SD, 1'b1, 1'b0);
    push_dig(1, SD, 1'b1, 1'b0);
    push_dig(2, S0, 1'b1, 1'b0);

    // Timer flash restarts from a cleared blink counter: first blank at edge 181.
    wait_cyc(172);
    timer_buzzer = 1'b1;
    push(6'b111111, S0, 1'b1, 1'b0);

    wait_cyc(182);
    timer_buzzer = 1'b0;
    push_dig(3, S0, 1'b1, 1'b0);
    push_dig(4, S3, 1'b1, 1'b0);
    push_dig(5, S0, 1'b1, 1'b0);

    wait_cyc(191);
    done = 1'b1;
  end

endmodule

// File: doc/clock_display_scanner.md
# clock_display_scanner

Downstream consumer of `digital_clock`. Takes the binary time outputs `hr`, `min`, `sec` and `AM_PM`, plus the buzzer flags, and drives a 6-digit multiplexed, common-anode seven-segment display (HH MM SS). It snapshots the time once per scan frame to avoid tearing, converts each field to two BCD digits, blanks the leading hour zero in 12-hour mode, drives a colon, and flashes the display while any buzzer is active.

## Interface
- `REFRESH_DIV`, default 1000: clock cycles each digit stays lit (≥2).
- `BLINK_DIV`, default 250000: clock cycles per half-period of the buzzer flash (≥2).
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `hr` in 6: hour, binary.
- `min` in 6: minute, binary.
- `sec` in 6: second, binary.
- `AM_PM` in 1: 1 = PM.
- `AM_mode` in 1: 1 = 12-hour display.
- `alarm_buzzer` in 1: alarm active.
- `timer_buzzer` in 1: timer active.
- `an` out 6: digit enables, active-low. Bit 0 = seconds ones … bit 5 = hour tens.
- `seg` out 7: segments, active-low, order {g,f,e,d,c,b,a}.
- `dp` out 1: decimal point, active-low.
- `pm_led` out 1: PM indicator.

## Operation
- **Refresh counter** counts 0..REFRESH_DIV-1. At the terminal count it wraps and advances the digit index `idx` from 0 to 5, then back to 0.
- **Snapshot:** on the cycle where `idx` wraps 5→0, `hr`, `min`, `sec`, `AM_PM` and `AM_mode` are registered. All six digits of a frame come from one snapshot, so input changes mid-frame are invisible until the next frame.
- **BCD conversion** per field, range 0..59:
  - tens = v/10, ones = v%10.
  - For v > 59, both digits of that field show a dash (`seg` = 7'b0111111).
- **Segment codes** for 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Blank is 1111111.
- **Leading zero:** the hour tens digit is blank when snapshot `AM_mode` = 1 and hour tens = 0. In 24-hour mode, a leading 0 is shown.
- **Colon:** `dp` = 0 on `idx` 4 (hour ones) and `idx` 2 (minute ones) when snapshot `sec` is even. Otherwise `dp` = 1.
- **Flash:** a blink counter toggles `blink_phase` every BLINK_DIV cycles.
  - While `alarm_buzzer | timer_buzzer` is high and `blink_phase` = 1, `an` = 6'b111111. Scanning and the snapshot continue regardless.
  - While neither buzzer is high, the blink counter and `blink_phase` are held at 0.
- **PM LED:** `pm_led` = snapshot `AM_mode` & snapshot `AM_PM`.

## Timing
- **Reset values:** `an` = 6'b111111, `seg` = 7'b1111111, `dp` = 1, `pm_led` = 0. `idx`, both counters, `blink_phase` and the snapshot are all 0.
- `an`/`seg`/`dp` are registered and update the cycle after `idx` changes (1-cycle latency). `an` has exactly one bit low, or all bits high.
- **First frame after reset:** the snapshot is loaded on the first 5→0 wrap. Until then the all-zero snapshot is displayed, with the hour tens digit shown because snapshot `AM_mode` = 0 after reset.
- **Frame period** = 6·REFRESH_DIV cycles.
- **Buzzer:**
  - Rise to first blank takes BLINK_DIV+1 cycles.
  - When the buzzer deasserts, `an` resumes scanning on the next cycle.
- **Reset mid-frame:** all state is cleared immediately, asynchronously. Scanning restarts at `idx` 0.
- **Simultaneous events:** the snapshot wrap and a blink toggle on the same cycle are independent; both take effect.

## Structure
- Package `clock_disp_pkg` holds:
  - `NUM_DIGITS` = 6,
  - the segment code constants `SEG_0`..`SEG_9`, `SEG_BLANK`, `SEG_DASH`,
  - a `seg_encode` function.
- Sub-module `bin2bcd60`, combinational:
  - converts a 6-bit value to tens/ones nibbles,
  - asserts an `invalid` flag for values > 59;
  - instantiated three times (hour, minute, second).

## Test plan
All scenarios use REFRESH_DIV = 4 and BLINK_DIV = 8.
1. **Reset:** assert `reset` mid-scan → next cycle `an` = 111111, `seg` = 1111111, `dp` = 1, `pm_led` = 0; after release `an` cycles 111110, 111101, … every 4 cycles.
2. **24-hour display:** `hr` = 9, `min` = 5, `sec` = 42, `AM_mode` = 0; after one frame the digits show 0,9,0,5,4,2 with the correct codes; `dp` is low on `idx` 4 and 2; `pm_led` = 0.
3. **12-hour, PM:** `hr` = 3, `AM_mode` = 1, `AM_PM` = 1 → hour tens `seg` = 1111111, `pm_led` = 1; with `sec` = 43 `dp` stays 1 on all digits.
4. **Tearing:** change `min` from 59 to 0 while `idx` = 3 → the rest of that frame still shows 59; the next frame shows 00.
5. **Invalid value:** `sec` = 63 → both seconds digits show `seg` = 0111111.
6. **Flash:** raise `alarm_buzzer` → after 9 cycles `an` = 111111 for 8 cycles, then scanning for 8 cycles, repeating; drop `alarm_buzzer` → scanning resumes the next cycle and `blink_phase` = 0.
